// File: rtl/multi_edge_seq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : edge_seq_pkg
// Description : Shared types, default sizing and helpers for the multi-channel
//               rising-edge sequence counter.
// Contents    : state_t       - per-channel FSM state encoding
//               DEF_NUM_CH    - default channel count
//               DEF_CNT_W     - default rise-counter / target width
//               DEF_GAP_W     - default gap-counter / max-gap width
//               eff_target()  - maps a programmed target of 0 onto 1
// Revision    : 1.0 - initial release
// ============================================================================
package edge_seq_pkg;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_GAP_W  = 8;

   // IDLE : waiting for the arming rise
   // ARMED: counting further rises, gap counter running
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   // A target of zero would complete before any rise was seen, which has no
   // useful meaning; it behaves exactly like a target of one.
   function automatic logic [31:0] eff_target(input logic [31:0] target);
      return (target == 32'd0) ? 32'd1 : target;
   endfunction

endpackage : edge_seq_pkg
`default_nettype wire

// File: rtl/multi_edge_seq_counter_if.sv
`default_nettype none
// ============================================================================
// Interface   : multi_edge_seq_counter_if
// Description : Control, configuration and status bundle of the
//               multi-channel rising-edge sequence counter.
// Signals     : enable      - global enable, low freezes all channels
//               clear       - synchronous clear of all channels
//               start       - per-channel event inputs
//               cfg_target  - rises required for done (0 acts as 1)
//               cfg_max_gap - rise-free edges allowed (0 disables timeout)
//               done        - per-channel one-cycle completion pulse
//               timeout     - per-channel one-cycle gap-expiry pulse
//               busy        - per-channel ARMED indication
//               count       - flattened per-channel live rise counts
// Modports    : master - drives control/config, observes status
//               slave  - the counter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_edge_seq_counter_if
   import edge_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int GAP_W  = DEF_GAP_W
);

   logic                      enable;
   logic                      clear;
   logic [NUM_CH-1:0]         start;
   logic [CNT_W-1:0]          cfg_target;
   logic [GAP_W-1:0]          cfg_max_gap;
   logic [NUM_CH-1:0]         done;
   logic [NUM_CH-1:0]         timeout;
   logic [NUM_CH-1:0]         busy;
   logic [NUM_CH*CNT_W-1:0]   count;

   modport master (
      output enable, clear, start, cfg_target, cfg_max_gap,
      input  done, timeout, busy, count
   );

   modport slave (
      input  enable, clear, start, cfg_target, cfg_max_gap,
      output done, timeout, busy, count
   );

endinterface : multi_edge_seq_counter_if
`default_nettype wire

// File: rtl/multi_edge_seq_counter_chan.sv
`default_nettype none
// ============================================================================
// Module      : edge_seq_chan
// Description : One channel of the rising-edge sequence counter: edge
//               detector, IDLE/ARMED FSM, rise counter and gap counter.
// Ports       : clk         - system clock (posedge)
//               rst_n       - asynchronous active-low reset
//               enable      - low freezes FSM, count and gap
//               clear       - synchronous return to IDLE, count/gap zeroed
//               start       - event input, synchronous to clk
//               cfg_target  - rises required for done (0 acts as 1)
//               cfg_max_gap - rise-free edges allowed (0 disables timeout)
//               done        - one-cycle pulse after the completing rise
//               timeout     - one-cycle pulse after the expiring edge
//               busy        - channel is ARMED
//               count       - live rise count, held after done/timeout
// Revision    : 1.0 - initial release
// ============================================================================
module edge_seq_chan
   import edge_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int GAP_W = DEF_GAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [GAP_W-1:0] cfg_max_gap,
   output logic             done,
   output logic             timeout,
   output logic             busy,
   output logic [CNT_W-1:0] count
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_prev;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [GAP_W-1:0]   r_gap;
   logic [GAP_W-1:0]   w_gap_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;

   logic               w_rise;
   logic [CNT_W:0]     w_target;
   logic [CNT_W:0]     w_count_inc;
   logic [GAP_W:0]     w_gap_inc;
   logic               w_gap_expire;
   logic [GAP_W-1:0]   w_gap_step;

   // prev_start tracks the input on every edge, independent of enable and
   // clear, so re-enabling never manufactures a rise from stale history.
   assign w_rise = start & ~r_prev;

   // Comparisons are done one bit wider so the increment itself can never
   // alias back onto a small value.
   assign w_target    = (CNT_W+1)'(eff_target(32'(cfg_target)));
   assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
   assign w_gap_inc   = {1'b0, r_gap} + {{GAP_W{1'b0}}, 1'b1};

   assign w_gap_expire = (cfg_max_gap != '0) &&
                         (w_gap_inc == {1'b0, cfg_max_gap});

   // Saturate rather than wrap: with the timeout disabled, or after the
   // limit was lowered below the running gap, the counter parks at all-ones.
   assign w_gap_step = (&r_gap) ? r_gap : w_gap_inc[GAP_W-1:0];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_prev    <= 1'b0;
         r_count   <= '0;
         r_gap     <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_prev    <= start;
         r_count   <= w_count_nxt;
         r_gap     <= w_gap_nxt;
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: clear, then enable-low, then rise, then gap
   // expiry, so a rise on the expiring edge keeps the sequence alive.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_gap_nxt     = r_gap;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;

      if (clear) begin
         w_state_nxt = IDLE;
         w_count_nxt = '0;
         w_gap_nxt   = '0;
      end else if (enable) begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                  w_gap_nxt   = '0;
                  if (w_target == {{CNT_W{1'b0}}, 1'b1}) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ARMED;
                  end
               end
            end

            ARMED: begin
               if (w_rise) begin
                  w_count_nxt = w_count_inc[CNT_W-1:0];
                  w_gap_nxt   = '0;
                  // >= rather than == so a target lowered below the current
                  // count completes on the next rise instead of running on.
                  if (w_count_inc >= w_target) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end else if (w_gap_expire) begin
                  w_timeout_nxt = 1'b1;
                  w_gap_nxt     = '0;
                  w_state_nxt   = IDLE;
               end else begin
                  w_gap_nxt = w_gap_step;
               end
            end

            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign done    = r_done;
   assign timeout = r_timeout;
   assign busy    = (r_state == ARMED);
   assign count   = r_count;

endmodule : edge_seq_chan
`default_nettype wire

// File: rtl/multi_edge_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_edge_seq_counter
// Description : Multi-channel rising-edge sequence counter. Each channel arms
//               on its first rise of start, counts further rises up to a
//               programmable target (done) and aborts if the rise-free gap
//               reaches a programmable limit (timeout).
// Ports       : clk   - system clock (posedge)
//               rst_n - asynchronous active-low reset
//               bus   - slave side of multi_edge_seq_counter_if:
//                       enable, clear, start[NUM_CH], cfg_target, cfg_max_gap
//                       in; done, timeout, busy [NUM_CH], count
//                       [NUM_CH*CNT_W] out (channel i at [i*CNT_W +: CNT_W])
// Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_seq_counter
   import edge_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int GAP_W  = DEF_GAP_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   multi_edge_seq_counter_if.slave    bus
);

   logic [NUM_CH-1:0]       w_done;
   logic [NUM_CH-1:0]       w_timeout;
   logic [NUM_CH-1:0]       w_busy;
   logic [NUM_CH*CNT_W-1:0] w_count;

   // Channels share only enable, clear and configuration; everything else is
   // private, so simultaneous events on different channels never interact.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      edge_seq_chan #(
         .CNT_W (CNT_W),
         .GAP_W (GAP_W)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable      (bus.enable),
         .clear       (bus.clear),
         .start       (bus.start[i]),
         .cfg_target  (bus.cfg_target),
         .cfg_max_gap (bus.cfg_max_gap),
         .done        (w_done[i]),
         .timeout     (w_timeout[i]),
         .busy        (w_busy[i]),
         .count       (w_count[i*CNT_W +: CNT_W])
      );
   end : g_chan

   assign bus.done    = w_done;
   assign bus.timeout = w_timeout;
   assign bus.busy    = w_busy;
   assign bus.count   = w_count;

endmodule : multi_edge_seq_counter
`default_nettype wire

// File: tb/tb_multi_edge_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_edge_seq_counter
// Description : Self-checking bench for multi_edge_seq_counter. A behavioural
//               model (sequence length, rise-free gap and an in-sequence flag
//               per channel) predicts every output on every edge; directed
//               scenarios add end-of-scenario checks against fixed values,
//               followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_edge_seq_counter;

   localparam int NCH = 4;
   localparam int CW  = 4;
   localparam int GW  = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   multi_edge_seq_counter_if #(.NUM_CH(NCH), .CNT_W(CW), .GAP_W(GW)) bus ();

   multi_edge_seq_counter #(.NUM_CH(NCH), .CNT_W(CW), .GAP_W(GW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   bit m_prev  [NCH];
   bit m_inseq [NCH];
   int m_len   [NCH];
   int m_gap   [NCH];
   bit m_done  [NCH];
   bit m_to    [NCH];

   // observed-event tallies for scenario-level checks
   int done_seen [NCH];
   int to_seen   [NCH];
   int busy_seen [NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_prev[c] = 0; m_inseq[c] = 0; m_len[c] = 0;
         m_gap[c] = 0;  m_done[c] = 0;  m_to[c] = 0;
      end
   endtask

   task automatic model_edge();
      int  tgt;
      bit  rise;
      tgt = (bus.cfg_target == 0) ? 1 : int'(bus.cfg_target);
      for (int c = 0; c < NCH; c++) begin
         rise      = bus.start[c] && !m_prev[c];
         m_prev[c] = bus.start[c];
         m_done[c] = 0;
         m_to[c]   = 0;
         if (bus.clear) begin
            m_inseq[c] = 0; m_len[c] = 0; m_gap[c] = 0;
         end else if (bus.enable) begin
            if (rise) begin
               m_len[c] = m_inseq[c] ? m_len[c] + 1 : 1;
               m_gap[c] = 0;
               if (m_len[c] >= tgt) begin
                  m_done[c]  = 1;
                  m_inseq[c] = 0;
               end else begin
                  m_inseq[c] = 1;
               end
            end else if (m_inseq[c]) begin
               m_gap[c]++;
               if (bus.cfg_max_gap != 0 && m_gap[c] == int'(bus.cfg_max_gap)) begin
                  m_to[c]    = 1;
                  m_inseq[c] = 0;
                  m_gap[c]   = 0;
               end
            end
         end
      end
   endtask

   task automatic clear_seen();
      for (int c = 0; c < NCH; c++) begin
         done_seen[c] = 0; to_seen[c] = 0; busy_seen[c] = 0;
      end
   endtask

   // One clock: inputs already stable, model advances at the edge, outputs
   // compared on the following falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("ch%0d.done@%0d", c, cyc),    32'(bus.done[c]),    32'(m_done[c]));
         chk($sformatf("ch%0d.timeout@%0d", c, cyc), 32'(bus.timeout[c]), 32'(m_to[c]));
         chk($sformatf("ch%0d.busy@%0d", c, cyc),    32'(bus.busy[c]),    32'(m_inseq[c]));
         chk($sformatf("ch%0d.count@%0d", c, cyc),   32'(bus.count[c*CW +: CW]), 32'(m_len[c]));
         done_seen[c] += int'(bus.done[c]);
         to_seen[c]   += int'(bus.timeout[c]);
         busy_seen[c] += int'(bus.busy[c]);
      end
   endtask

   // One rise every four edges: two high, two low.
   task automatic pulse_train(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         bus.start[ch] = 1'b1; tick(); tick();
         bus.start[ch] = 1'b0; tick(); tick();
      end
   endtask

   task automatic idle_all();
      bus.start = '0;
      bus.clear = 1'b1; tick();
      bus.clear = 1'b0; tick();
      clear_seen();
   endtask

   function automatic logic [31:0] cnt_of(input int ch);
      return 32'(bus.count[ch*CW +: CW]);
   endfunction

   initial begin
      bus.enable      = 1'b1;
      bus.clear       = 1'b0;
      bus.start       = '0;
      bus.cfg_target  = 4'd3;
      bus.cfg_max_gap = 8'd8;
      rst_n           = 1'b0;
      model_reset();
      clear_seen();

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("reset.done",    32'(bus.done),    32'd0);
      chk("reset.timeout", 32'(bus.timeout), 32'd0);
      chk("reset.busy",    32'(bus.busy),    32'd0);
      chk("reset.count",   32'(bus.count),   32'd0);
      rst_n = 1'b1;
      tick();

      // ---- target 3, max gap 8: clean completion ----
      idle_all();
      pulse_train(0, 3);
      tick();
      chk("t3g8.done_cnt", 32'(done_seen[0]), 32'd1);
      chk("t3g8.to_cnt",   32'(to_seen[0]),   32'd0);
      chk("t3g8.count",    cnt_of(0),         32'd3);
      chk("t3g8.busy",     32'(bus.busy[0]),  32'd0);

      // ---- max gap 3: every sequence times out ----
      bus.cfg_max_gap = 8'd3;
      idle_all();
      pulse_train(0, 3);
      chk("g3.done_cnt", 32'(done_seen[0]), 32'd0);
      chk("g3.to_cnt",   32'(to_seen[0]),   32'd3);
      chk("g3.count",    cnt_of(0),         32'd1);

      // ---- max gap 4: rise lands just in time ----
      bus.cfg_max_gap = 8'd4;
      idle_all();
      pulse_train(0, 3);
      chk("g4.done_cnt", 32'(done_seen[0]), 32'd1);
      chk("g4.to_cnt",   32'(to_seen[0]),   32'd0);

      // ---- target 0 and 1: single-rise completion ----
      bus.cfg_max_gap = 8'd8;
      for (int t = 0; t < 2; t++) begin
         bus.cfg_target = CW'(t);
         idle_all();
         pulse_train(0, 1);
         chk($sformatf("tgt%0d.done_cnt", t), 32'(done_seen[0]), 32'd1);
         chk($sformatf("tgt%0d.busy_cnt", t), 32'(busy_seen[0]), 32'd0);
         chk($sformatf("tgt%0d.count", t),    cnt_of(0),         32'd1);
      end

      // ---- asynchronous reset mid-sequence ----
      bus.cfg_target = 4'd3;
      idle_all();
      pulse_train(0, 2);
      chk("rst.count_before", cnt_of(0), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst.async_busy",  32'(bus.busy),  32'd0);
      chk("rst.async_count", 32'(bus.count), 32'd0);
      bus.start[0] = 1'b1;
      #1 rst_n = 1'b1;
      tick();
      chk("rst.first_rise_count", cnt_of(0), 32'd1);
      bus.start[0] = 1'b0; tick(); tick();

      // ---- enable low across two rises ----
      idle_all();
      pulse_train(0, 1);
      bus.enable = 1'b0;
      pulse_train(0, 2);
      tick(); tick();
      chk("en.count_frozen", cnt_of(0), 32'd1);
      chk("en.no_pulses",    32'(done_seen[0] + to_seen[0]), 32'd0);
      bus.enable = 1'b1;
      pulse_train(0, 2);
      chk("en.done_cnt", 32'(done_seen[0]), 32'd1);
      chk("en.to_cnt",   32'(to_seen[0]),   32'd0);

      // ---- four staggered channels, clear on ch2's final rise ----
      idle_all();
      for (int c2 = 0; c2 < 32; c2++) begin
         for (int c = 0; c < NCH; c++) begin
            int base;
            base = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 11 : 20;
            bus.start[c] = (c2 >= base) && (c2 < base + 12) && (((c2 - base) % 4) < 2);
         end
         bus.clear = (c2 == 19);
         tick();
      end
      bus.clear = 1'b0;
      bus.start = '0;
      tick();
      chk("mc.ch0_done", 32'(done_seen[0]), 32'd1);
      chk("mc.ch1_done", 32'(done_seen[1]), 32'd1);
      chk("mc.ch2_done", 32'(done_seen[2]), 32'd0);
      chk("mc.ch3_done", 32'(done_seen[3]), 32'd1);
      chk("mc.ch2_count", cnt_of(2),        32'd0);

      // ---- randomized soak against the model ----
      for (int n = 0; n < 1500; n++) begin
         if (n % 50 == 0) begin
            bus.cfg_target  = CW'($urandom_range(0, 6));
            bus.cfg_max_gap = GW'($urandom_range(0, 8));
         end
         for (int c = 0; c < NCH; c++)
            bus.start[c] = ($urandom_range(0, 99) < 40);
         bus.enable = ($urandom_range(0, 99) < 92);
         bus.clear  = ($urandom_range(0, 99) < 2);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_multi_edge_seq_counter
`default_nettype wire
